// File: rtl/rx_image_pkg.sv
// Shared definitions for the UART image loader: FSM state encoding, address and
// dimension widths, the default maximum image dimension and a dimension check.
// Optional feature macro: RX_IMAGE_LOADER_CHECKSUM_EN adds the S_CHK state.
package rx_image_pkg;

   localparam int ADDR_W          = 12;
   localparam int DIM_W           = 7;
   localparam int MAX_DIM_DEFAULT = 64;

`ifdef RX_IMAGE_LOADER_CHECKSUM_EN
   typedef enum logic [2:0] {
      S_W    = 3'd0,
      S_H    = 3'd1,
      S_PIX  = 3'd2,
      S_CHK  = 3'd3,
      S_DONE = 3'd4
   } state_t;
`else
   typedef enum logic [2:0] {
      S_W    = 3'd0,
      S_H    = 3'd1,
      S_PIX  = 3'd2,
      S_DONE = 3'd4
   } state_t;
`endif

   // A dimension byte is legal when it lies in 1..max_dim.
   function automatic logic dim_ok(input logic [7:0] v, input logic [7:0] max_dim);
      return (v != 8'd0) && (v <= max_dim);
   endfunction

endpackage

// File: rtl/rx_byte_strobe.sv
// Rising-edge detector on the UART receiver's level-high byte-valid flag.
// The delayed copy powers up high so a byte left pending across reset is ignored.
module rx_byte_strobe (
   input  logic clk,
   input  logic reset,
   input  logic rx_ready,
   output logic byte_stb
);

   logic rx_ready_q;

   // Delay rx_ready one cycle; preset high so a level already present at reset release never strobes
   always_ff @(posedge clk) begin
      if (reset) begin
         rx_ready_q <= 1'b1;
      end else begin
         rx_ready_q <= rx_ready;
      end
   end

   assign byte_stb = rx_ready & ~rx_ready_q;

endmodule

// File: rtl/rx_image_loader.sv
// Loads a binary image from a UART byte stream: width byte, height byte, then
// width*height pixel bytes thresholded to 1 bit and written to frame memory.
// Optional feature macro: RX_IMAGE_LOADER_CHECKSUM_EN expects one trailing byte
// equal to the XOR of all raw pixel bytes before the frame is accepted.
module rx_image_loader
   import rx_image_pkg::*;
#(
   parameter logic [7:0] THRESHOLD = 8'd128,
   parameter int         MAX_DIM   = MAX_DIM_DEFAULT
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [7:0]        rx_data,
   input  logic              rx_ready,
   input  logic              abort,
   output logic              wr_en,
   output logic [ADDR_W-1:0] wr_addr,
   output logic              wr_data,
   output logic [DIM_W-1:0]  img_w,
   output logic [DIM_W-1:0]  img_h,
   output logic              busy,
   output logic              frame_done,
   output logic              frame_err
);

   localparam logic [7:0] MAX_DIM_B = 8'(MAX_DIM);

   state_t            state;
   logic              byte_stb;
   logic [DIM_W-1:0]  col;
   logic [DIM_W-1:0]  row;
   logic [ADDR_W-1:0] addr;
   logic              col_last;
   logic              row_last;
`ifdef RX_IMAGE_LOADER_CHECKSUM_EN
   logic [7:0]        csum;
`endif

   rx_byte_strobe u_strobe (
      .clk      (clk),
      .reset    (reset),
      .rx_ready (rx_ready),
      .byte_stb (byte_stb)
   );

   assign col_last = (col == img_w - DIM_W'(1));
   assign row_last = (row == img_h - DIM_W'(1));

   // Frame FSM with pixel counters; every output is registered here, abort overrides any byte
   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= S_W;
         wr_en      <= 1'b0;
         wr_addr    <= '0;
         wr_data    <= 1'b0;
         img_w      <= '0;
         img_h      <= '0;
         busy       <= 1'b0;
         frame_done <= 1'b0;
         frame_err  <= 1'b0;
         col        <= '0;
         row        <= '0;
         addr       <= '0;
`ifdef RX_IMAGE_LOADER_CHECKSUM_EN
         csum       <= '0;
`endif
      end else begin
         wr_en      <= 1'b0;
         frame_done <= 1'b0;
         frame_err  <= 1'b0;
         if (abort) begin
            state <= S_W;
            busy  <= 1'b0;
         end else begin
            case (state)
               S_W: begin
                  if (byte_stb) begin
                     if (dim_ok(rx_data, MAX_DIM_B)) begin
                        img_w <= rx_data[DIM_W-1:0];
                        state <= S_H;
                        busy  <= 1'b1;
                     end else begin
                        frame_err <= 1'b1;
                     end
                  end
               end
               S_H: begin
                  if (byte_stb) begin
                     if (dim_ok(rx_data, MAX_DIM_B)) begin
                        img_h <= rx_data[DIM_W-1:0];
                        col   <= '0;
                        row   <= '0;
                        addr  <= '0;
`ifdef RX_IMAGE_LOADER_CHECKSUM_EN
                        csum  <= '0;
`endif
                        state <= S_PIX;
                     end else begin
                        frame_err <= 1'b1;
                        state     <= S_W;
                        busy      <= 1'b0;
                     end
                  end
               end
               S_PIX: begin
                  if (byte_stb) begin
                     wr_en   <= 1'b1;
                     wr_addr <= addr;
                     wr_data <= (rx_data >= THRESHOLD);
                     addr    <= addr + ADDR_W'(1);
`ifdef RX_IMAGE_LOADER_CHECKSUM_EN
                     csum    <= csum ^ rx_data;
`endif
                     if (col_last) begin
                        col <= '0;
                        row <= row + DIM_W'(1);
                     end else begin
                        col <= col + DIM_W'(1);
                     end
                     // The last pixel is the one that wraps the final row
                     if (col_last && row_last) begin
`ifdef RX_IMAGE_LOADER_CHECKSUM_EN
                        state      <= S_CHK;
`else
                        state      <= S_DONE;
                        frame_done <= 1'b1;
`endif
                     end
                  end
               end
`ifdef RX_IMAGE_LOADER_CHECKSUM_EN
               S_CHK: begin
                  if (byte_stb) begin
                     if (rx_data == csum) begin
                        state      <= S_DONE;
                        frame_done <= 1'b1;
                     end else begin
                        frame_err <= 1'b1;
                        state     <= S_W;
                        busy      <= 1'b0;
                     end
                  end
               end
`endif
               S_DONE: begin
                  state <= S_W;
                  busy  <= 1'b0;
               end
               default: begin
                  state <= S_W;
                  busy  <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_rx_image_loader.sv
// Self-checking bench for rx_image_loader: directed steps plus randomized byte
// streams, scored against a stream-level reference model of the image protocol.
module tb_rx_image_loader;

   typedef logic [7:0] bq_t[$];

   logic        clk = 1'b0;
   logic        reset;
   logic [7:0]  rx_data;
   logic        rx_ready;
   logic        abort;
   logic        wr_en;
   logic [11:0] wr_addr;
   logic        wr_data;
   logic [6:0]  img_w;
   logic [6:0]  img_h;
   logic        busy;
   logic        frame_done;
   logic        frame_err;

   rx_image_loader dut (
      .clk        (clk),
      .reset      (reset),
      .rx_data    (rx_data),
      .rx_ready   (rx_ready),
      .abort      (abort),
      .wr_en      (wr_en),
      .wr_addr    (wr_addr),
      .wr_data    (wr_data),
      .img_w      (img_w),
      .img_h      (img_h),
      .busy       (busy),
      .frame_done (frame_done),
      .frame_err  (frame_err)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   // observed activity
   int act_addr[$];
   int act_data[$];
   int done_cnt = 0;
   int err_cnt  = 0;
   int busy_cyc = 0;
   int cap_w    = 0;
   int cap_h    = 0;

   // expectations from the model
   int exp_addr[$];
   int exp_data[$];
   int exp_done;
   int exp_err;
   int exp_w;
   int exp_h;

   // snapshot bases
   int b_wr, b_done, b_err, b_busy;

   // Record DUT activity away from the active edge
   always @(negedge clk) begin
      if (wr_en) begin
         act_addr.push_back(int'(wr_addr));
         act_data.push_back(int'(wr_data));
      end
      if (frame_done) begin
         done_cnt++;
         cap_w = int'(img_w);
         cap_h = int'(img_h);
      end
      if (frame_err) err_cnt++;
      if (busy) busy_cyc++;
   end

   task automatic chk(input string tag, input int obs, input int exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Stream-level reference: walks the byte list with the protocol rules
   task automatic model(input bq_t s);
      int i, n, w, h, k;
      logic [7:0] cs;
      exp_addr.delete();
      exp_data.delete();
      exp_done = 0;
      exp_err  = 0;
      exp_w    = 0;
      exp_h    = 0;
      i = 0;
      n = s.size();
      while (i < n) begin
         w = int'(s[i]); i++;
         if (w < 1 || w > 64) begin exp_err++; continue; end
         if (i >= n) break;
         h = int'(s[i]); i++;
         if (h < 1 || h > 64) begin exp_err++; continue; end
         cs = 8'h00;
         for (k = 0; k < w * h && i < n; k++) begin
            exp_addr.push_back(k);
            exp_data.push_back((s[i] >= 8'd128) ? 1 : 0);
            cs = cs ^ s[i];
            i++;
         end
         if (k < w * h) break;
`ifdef RX_IMAGE_LOADER_CHECKSUM_EN
         if (i >= n) break;
         if (s[i] == cs) begin exp_done++; exp_w = w; exp_h = h; end
         else exp_err++;
         i++;
`else
         exp_done++; exp_w = w; exp_h = h;
`endif
      end
   endtask

   function automatic bq_t frame(input int w, input int h, input bq_t px);
      bq_t s;
      logic [7:0] cs;
      cs = 8'h00;
      s.push_back(8'(w));
      s.push_back(8'(h));
      foreach (px[j]) begin
         s.push_back(px[j]);
         cs = cs ^ px[j];
      end
`ifdef RX_IMAGE_LOADER_CHECKSUM_EN
      s.push_back(cs);
`endif
      return s;
   endfunction

   function automatic bq_t rand_px(input int n);
      bq_t p;
      for (int j = 0; j < n; j++) p.push_back(8'($urandom_range(0, 255)));
      return p;
   endfunction

   task automatic snap();
      b_wr   = act_addr.size();
      b_done = done_cnt;
      b_err  = err_cnt;
      b_busy = busy_cyc;
   endtask

   // Called at a falling edge; presents one byte for 'hold' cycles then releases
   task automatic send_byte(input logic [7:0] b, input int hold);
      rx_data  = b;
      rx_ready = 1'b1;
      repeat (hold) @(negedge clk);
      rx_ready = 1'b0;
      @(negedge clk);
   endtask

   task automatic send_stream(input bq_t s, input int hold0);
      foreach (s[j]) send_byte(s[j], (j == 0) ? hold0 : 1);
   endtask

   task automatic idle();
      repeat (4) @(negedge clk);
   endtask

   task automatic compare(input string tag);
      chk({tag, "_nwr"}, act_addr.size() - b_wr, exp_addr.size());
      for (int k = 0; k < exp_addr.size() && b_wr + k < act_addr.size(); k++) begin
         chk({tag, "_addr"}, act_addr[b_wr + k], exp_addr[k]);
         chk({tag, "_data"}, act_data[b_wr + k], exp_data[k]);
      end
      chk({tag, "_done"}, done_cnt - b_done, exp_done);
      chk({tag, "_err"}, err_cnt - b_err, exp_err);
      if (exp_done > 0) begin
         chk({tag, "_img_w"}, cap_w, exp_w);
         chk({tag, "_img_h"}, cap_h, exp_h);
      end
   endtask

   task automatic run(input bq_t s, input int hold0, input string tag);
      snap();
      model(s);
      send_stream(s, hold0);
      idle();
      compare(tag);
   endtask

   initial begin
      bq_t s, px;
      logic [7:0] v;

      // reset with a stale byte already pending
      reset    = 1'b1;
      rx_ready = 1'b1;
      rx_data  = 8'd3;
      abort    = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_wr_en", int'(wr_en), 0);
      chk("rst_wr_addr", int'(wr_addr), 0);
      chk("rst_wr_data", int'(wr_data), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_done", int'(frame_done), 0);
      chk("rst_err", int'(frame_err), 0);
      chk("rst_img_w", int'(img_w), 0);
      chk("rst_img_h", int'(img_h), 0);
      snap();
      reset = 1'b0;
      repeat (5) @(negedge clk);
      chk("stale_busy", int'(busy), 0);
      chk("stale_busycyc", busy_cyc - b_busy, 0);
      chk("stale_err", err_cnt - b_err, 0);
      rx_ready = 1'b0;
      @(negedge clk);

      // basic 3x2 frame, width byte held for 20 cycles
      px = '{8'h00, 8'hFF, 8'h80, 8'h7F, 8'h90, 8'h10};
      run(frame(3, 2, px), 20, "basic");

      // illegal widths and heights
      s = '{8'd0, 8'd65};
      run(s, 1, "badw");
      chk("badw_busy", busy_cyc - b_busy, 0);
      s = '{8'd2, 8'd0, 8'd2, 8'd65};
      run(s, 1, "badh");

      // abort coinciding with the third pixel strobe
      snap();
      s = '{8'd4, 8'd1, 8'h90, 8'h10};
      model(s);
      send_stream(s, 1);
      rx_data  = 8'hFF;
      rx_ready = 1'b1;
      abort    = 1'b1;
      @(negedge clk);
      abort    = 1'b0;
      rx_ready = 1'b0;
      idle();
      compare("abort");
      chk("abort_busy", int'(busy), 0);
      px = '{8'hC0};
      run(frame(1, 1, px), 1, "after_abort");

      // reset in the middle of a frame
      snap();
      s = '{8'd2, 8'd2, 8'h80};
      model(s);
      send_stream(s, 1);
      chk("mid_busy", int'(busy), 1);
      reset = 1'b1;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      idle();
      compare("midrst");
      chk("midrst_busy", int'(busy), 0);

`ifdef RX_IMAGE_LOADER_CHECKSUM_EN
      s = '{8'd2, 8'd1, 8'hA5, 8'h5A, 8'hFF};
      run(s, 1, "csum_ok");
      s = '{8'd2, 8'd1, 8'hA5, 8'h5A, 8'hFE};
      run(s, 1, "csum_bad");
`endif

      // randomized streams mixing rejects and valid frames
      for (int it = 0; it < 8; it++) begin
         s.delete();
         if ($urandom_range(0, 1) == 1) begin
            v = ($urandom_range(0, 1) == 1) ? 8'd0 : 8'($urandom_range(65, 255));
            s.push_back(v);
         end
         if ($urandom_range(0, 2) == 0) begin
            s.push_back(8'($urandom_range(1, 64)));
            s.push_back(8'($urandom_range(65, 255)));
         end
         begin
            int w, h;
            bq_t f;
            w = $urandom_range(1, 6);
            h = $urandom_range(1, 6);
            f = frame(w, h, rand_px(w * h));
`ifdef RX_IMAGE_LOADER_CHECKSUM_EN
            if ($urandom_range(0, 3) == 0) f[f.size() - 1] = f[f.size() - 1] ^ 8'h01;
`endif
            s = {s, f};
         end
         run(s, $urandom_range(1, 3), "rand");
      end

      // full-size 64x64 frame
      run(frame(64, 64, rand_px(4096)), 1, "max");
      if (act_addr.size() > 0) chk("max_last_addr", act_addr[act_addr.size() - 1], 4095);
      else chk("max_last_addr", -1, 4095);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
